mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the IF-stage fetch requester and the MEM-stage load/store requester.
- Generates the `inst_mem_wait` and `data_mem_wait` signals consumed by the hazard unit.
- Uses a 3-state FSM with data-first priority, a bounded starvation guard for fetch, and a bus timeout that returns an error instead of hanging the pipeline.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_timeout_ctr.sv | 36 +++
 rtl/mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    // Current owner of the bus transaction.
    typedef enum logic {
        OwnIf   = 1'b0,
        OwnData = 1'b1
    } arb_owner_e;

    // All-ones byte enable; wide enough for any supported DATA_W, sliced by users.
    localparam int unsigned BeMaxW = 128;
    localparam logic [BeMaxW-1:0] BE_ALL = '1;

endpackage

// File: rtl/mem_arb_timeout_ctr.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module mem_arb_timeout_ctr #(
    parameter int unsigned Width = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [Width-1:0] count_d, count_q;

    // Load takes priority; otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Data wins ties, except that fetch is forced through after MAX_DATA_STREAK
// consecutive data grants while it waits. A stuck bus aborts with an error.
// Define MEM_PORT_ARB_PERF_EN to add the 32-bit performance counter outputs.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_err,
    input  logic                data_req,
    input  logic                data_we,
    input  logic [DATA_W/8-1:0] data_be,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_valid,
    output logic                data_err,
    output logic                inst_mem_wait,
    output logic                data_mem_wait,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    output logic [31:0]         perf_if_grants,
    output logic [31:0]         perf_data_grants,
    output logic [31:0]         perf_timeouts,
    output logic [31:0]         perf_wait_cycles
`endif
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned ST_W = $clog2(MAX_DATA_STREAK + 1);

    arb_state_e  state_d, state_q;
    arb_owner_e  owner_d, owner_q;
    logic [ST_W-1:0]   streak_d, streak_q;
    logic              bus_req_d, bus_req_q, bus_we_d, bus_we_q;
    logic [BE_W-1:0]   bus_be_d, bus_be_q;
    logic [ADDR_W-1:0] bus_addr_d, bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_d, bus_wdata_q;
    logic [DATA_W-1:0] if_rdata_d, if_rdata_q, data_rdata_d, data_rdata_q;
    logic              if_valid_d, if_valid_q, if_err_d, if_err_q;
    logic              data_valid_d, data_valid_q, data_err_d, data_err_q;

    logic grant_if, grant_data, ack_done, to_done, done, owner_req, to_expired;
    logic [DATA_W-1:0] resp_data;

    assign grant_data = (state_q == StIdle) && data_req &&
                        !(if_req && (streak_q == ST_W'(MAX_DATA_STREAK)));
    assign grant_if   = (state_q == StIdle) && if_req && !grant_data;
    assign ack_done   = (state_q == StBusy) && bus_ack;
    assign to_done    = (state_q == StBusy) && !bus_ack && to_expired;
    assign done       = ack_done || to_done;
    // A dropped request at completion means the owner was flushed.
    assign owner_req  = (owner_q == OwnIf) ? if_req : data_req;
    assign resp_data  = (ack_done && !bus_we_q) ? bus_rdata : '0;

    mem_arb_timeout_ctr #(
        .Width(TO_W)
    ) u_timeout_ctr (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (grant_if || grant_data),
        .load_val_i(TO_W'(TIMEOUT_CYCLES - 1)),
        .en_i      (state_q == StBusy),
        .expired_o (to_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_if || grant_data) state_d = StBusy;
            StBusy:  if (done) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and response next values.
    always_comb begin
        owner_d      = owner_q;
        streak_d     = streak_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_be_d     = bus_be_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        if_rdata_d   = if_rdata_q;
        data_rdata_d = data_rdata_q;
        if_valid_d   = 1'b0;
        if_err_d     = 1'b0;
        data_valid_d = 1'b0;
        data_err_d   = 1'b0;

        if (grant_data) begin
            owner_d     = OwnData;
            bus_req_d   = 1'b1;
            bus_we_d    = data_we;
            bus_be_d    = data_be;
            bus_addr_d  = data_addr;
            bus_wdata_d = data_wdata;
            if (!if_req) begin
                streak_d = '0;
            end else if (streak_q != ST_W'(MAX_DATA_STREAK)) begin
                streak_d = streak_q + ST_W'(1);
            end
        end else if (grant_if) begin
            owner_d     = OwnIf;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_be_d    = BE_ALL[BE_W-1:0];
            bus_addr_d  = if_addr;
            bus_wdata_d = '0;
            streak_d    = '0;
        end

        if (done) begin
            bus_req_d = 1'b0;
            if (owner_q == OwnIf) begin
                if_rdata_d = resp_data;
                if_valid_d = owner_req;
                if_err_d   = owner_req && to_done;
            end else begin
                data_rdata_d = resp_data;
                data_valid_d = owner_req;
                data_err_d   = owner_req && to_done;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OwnIf;
            streak_q     <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            if_rdata_q   <= '0;
            data_rdata_q <= '0;
            if_valid_q   <= 1'b0;
            if_err_q     <= 1'b0;
            data_valid_q <= 1'b0;
            data_err_q   <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            streak_q     <= streak_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_be_q     <= bus_be_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            if_rdata_q   <= if_rdata_d;
            data_rdata_q <= data_rdata_d;
            if_valid_q   <= if_valid_d;
            if_err_q     <= if_err_d;
            data_valid_q <= data_valid_d;
            data_err_q   <= data_err_d;
        end
    end

    assign bus_req       = bus_req_q;
    assign bus_we        = bus_we_q;
    assign bus_be        = bus_be_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign if_rdata      = if_rdata_q;
    assign if_valid      = if_valid_q;
    assign if_err        = if_err_q;
    assign data_rdata    = data_rdata_q;
    assign data_valid    = data_valid_q;
    assign data_err      = data_err_q;
    assign inst_mem_wait = if_req && !if_valid_q;
    assign data_mem_wait = data_req && !data_valid_q;

`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] perf_if_d, perf_if_q, perf_data_d, perf_data_q;
    logic [31:0] perf_to_d, perf_to_q, perf_wait_d, perf_wait_q;

    // Wrapping event counters.
    always_comb begin
        perf_if_d   = perf_if_q + 32'(grant_if);
        perf_data_d = perf_data_q + 32'(grant_data);
        perf_to_d   = perf_to_q + 32'(to_done);
        perf_wait_d = perf_wait_q + 32'(inst_mem_wait || data_mem_wait);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_q   <= '0;
            perf_data_q <= '0;
            perf_to_q   <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_if_q   <= perf_if_d;
            perf_data_q <= perf_data_d;
            perf_to_q   <= perf_to_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    assign perf_if_grants   = perf_if_q;
    assign perf_data_grants = perf_data_q;
    assign perf_timeouts    = perf_to_q;
    assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_DATA_STREAK=4, TIMEOUT_CYCLES=16).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid, if_err;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_valid, data_err;
    logic        inst_mem_wait, data_mem_wait;
    logic        bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_data_grants, perf_timeouts, perf_wait_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .MAX_DATA_STREAK(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_valid     (if_valid),
        .if_err       (if_err),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_be      (data_be),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_valid   (data_valid),
        .data_err     (data_err),
        .inst_mem_wait(inst_mem_wait),
        .data_mem_wait(data_mem_wait),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_be       (bus_be),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack)
`ifdef MEM_PORT_ARB_PERF_EN
        ,
        .perf_if_grants  (perf_if_grants),
        .perf_data_grants(perf_data_grants),
        .perf_timeouts   (perf_timeouts),
        .perf_wait_cycles(perf_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until bus_req rises, bounded.
    task automatic wait_req(input string tag);
        int n = 0;
        tick();
        while (!bus_req && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(bus_req), 32'd1);
    endtask

    // With bus_req high now: wait 'delay' cycles, pulse ack; returns in the RESP cycle.
    task automatic serve(input int delay, input logic [31:0] rdata);
        for (int i = 0; i < delay; i++) tick();
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        string exp_seq;
        logic [7:0] ch;

        // Reset state.
        tick();
        check("rst_bus_req", 32'(bus_req), 0);
        check("rst_if_valid", 32'(if_valid), 0);
        check("rst_data_valid", 32'(data_valid), 0);
        check("rst_bus_addr", bus_addr, 0);
        rst_n = 1'b1;
        tick();

        // Single fetch, ack two cycles after bus_req.
        if_req  = 1'b1;
        if_addr = 32'h100;
        #1;
        check("f_wait_early", 32'(inst_mem_wait), 1);
        tick();
        check("f_bus_req", 32'(bus_req), 1);
        check("f_bus_addr", bus_addr, 32'h100);
        check("f_bus_we", 32'(bus_we), 0);
        check("f_bus_be", 32'(bus_be), 32'hF);
        tick();
        check("f_no_valid_yet", 32'(if_valid), 0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_0013;
        tick();
        check("f_wait_at_ack", 32'(inst_mem_wait), 0);
        bus_ack   = 1'b0;
        check("f_if_valid", 32'(if_valid), 1);
        check("f_if_rdata", if_rdata, 32'h13);
        check("f_if_err", 32'(if_err), 0);
        check("f_wait_done", 32'(inst_mem_wait), 0);
        check("f_bus_req_drop", 32'(bus_req), 0);
        if_req = 1'b0;
        tick();
        check("f_valid_one_cycle", 32'(if_valid), 0);

        // Simultaneous requests: data store goes first.
        if_req     = 1'b1;
        if_addr    = 32'h104;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'h3;
        data_addr  = 32'h200;
        data_wdata = 32'hDEAD_BEEF;
        tick();
        check("s_bus_addr", bus_addr, 32'h200);
        check("s_bus_we", 32'(bus_we), 1);
        check("s_bus_be", 32'(bus_be), 32'h3);
        check("s_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        serve(1, 32'h1234_5678);
        check("s_data_valid", 32'(data_valid), 1);
        check("s_data_rdata", data_rdata, 0);
        check("s_if_valid", 32'(if_valid), 0);
        data_req = 1'b0;
        data_we  = 1'b0;
        tick();
        check("s_no_issue_after_resp", 32'(bus_req), 0);
        tick();
        check("s_if_issue", 32'(bus_req), 1);
        check("s_if_addr", bus_addr, 32'h104);
        serve(0, 32'hAA);
        check("s_if_valid2", 32'(if_valid), 1);
        check("s_if_rdata", if_rdata, 32'hAA);
        if_req = 1'b0;
        tick();

        // Starvation guard: grant order D,D,D,D,I,D.
        exp_seq   = "DDDDID";
        if_req    = 1'b1;
        if_addr   = 32'h300;
        data_req  = 1'b1;
        data_addr = 32'h400;
        for (int i = 0; i < 6; i++) begin
            wait_req($sformatf("g%0d_req", i));
            ch = exp_seq[i];
            check($sformatf("g%0d_owner", i), bus_addr, (ch == "I") ? 32'h300 : 32'h400);
            serve(0, 32'hC0DE_0000 | 32'(i));
            check($sformatf("g%0d_ifv", i), 32'(if_valid), (ch == "I") ? 32'd1 : 32'd0);
            check($sformatf("g%0d_dv", i), 32'(data_valid), (ch == "I") ? 32'd0 : 32'd1);
        end
        if_req   = 1'b0;
        data_req = 1'b0;
        tick();

        // Timeout: no ack, bus_req high exactly 16 cycles.
        data_req  = 1'b1;
        data_addr = 32'h500;
        wait_req("t_req");
        cnt = 0;
        while (bus_req && cnt < 40) begin
            cnt++;
            tick();
        end
        check("t_req_cycles", 32'(cnt), 32'd16);
        check("t_data_valid", 32'(data_valid), 1);
        check("t_data_err", 32'(data_err), 1);
        check("t_data_rdata", data_rdata, 0);
        data_req = 1'b0;
        tick();
        check("t_err_one_cycle", 32'(data_err), 0);
        tick();
        tick();
        bus_ack   = 1'b1;
        bus_rdata = 32'h5555_5555;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = '0;
        check("t_late_ack_valid", 32'(data_valid), 0);
        check("t_late_ack_rdata", data_rdata, 0);
        check("t_late_ack_req", 32'(bus_req), 0);

        // Flush: if_req dropped one cycle into BUSY.
        if_req  = 1'b1;
        if_addr = 32'h600;
        wait_req("fl_req");
        tick();
        if_req = 1'b0;
        serve(1, 32'h77);
        check("fl_if_valid", 32'(if_valid), 0);
        check("fl_if_err", 32'(if_err), 0);
        tick();
        check("fl_if_valid_idle", 32'(if_valid), 0);
        data_req  = 1'b1;
        data_addr = 32'h700;
        wait_req("fl_data_req");
        check("fl_data_addr", bus_addr, 32'h700);
        serve(0, 32'h1234);
        check("fl_data_valid", 32'(data_valid), 1);
        check("fl_data_rdata", data_rdata, 32'h1234);
        data_req = 1'b0;
        tick();

        // Asynchronous reset mid-BUSY.
        data_req  = 1'b1;
        data_addr = 32'h800;
        wait_req("r_req");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("r_bus_req_async", 32'(bus_req), 0);
        data_req = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("r_idle_req%0d", i), 32'(bus_req), 0);
            check($sformatf("r_idle_dv%0d", i), 32'(data_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
